sprite_ram_arbiter: RTL

- Single-port arbiter and sequencer in front of one port of the sprite attribute RAM (32-bit words, non-registered output mode, 1-cycle read latency).
- Shares that port between two requesters:
  - the sprite renderer: read-only, real-time, default priority;
  - the host bus interface: reads and byte-enabled writes.
- A starvation counter forces a host slot after a bounded run of renderer grants.
- Registered command and read-return pipeline; each requester gets a tagged read-valid.

---
 rtl/sprite_ram_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/sprite_ram_arbiter.sv
// Single-port arbiter for the sprite attribute RAM: renderer-priority grants with a
// starvation guard for the host, registered command stage and tagged read return.
module sprite_ram_arbiter #(
    parameter int AWID       = 8,
    parameter int DWID       = 32,
    parameter int BENW       = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk_a_i,
    input  logic            rst_a_c,
    input  logic            spr_req_i,
    input  logic [AWID-1:0] spr_addr_i,
    output logic            spr_ack_o,
    output logic [DWID-1:0] spr_rdata_o,
    output logic            spr_rvalid_o,
    input  logic            host_req_i,
    input  logic            host_we_i,
    input  logic [AWID-1:0] host_addr_i,
    input  logic [DWID-1:0] host_wdata_i,
    input  logic [BENW-1:0] host_ben_i,
    output logic            host_ack_o,
    output logic [DWID-1:0] host_rdata_o,
    output logic            host_rvalid_o,
    output logic            ram_en_o,
    output logic            ram_we_o,
    output logic [AWID-1:0] ram_addr_o,
    output logic [DWID-1:0] ram_wdata_o,
    output logic [BENW-1:0] ram_ben_o,
    input  logic [DWID-1:0] ram_rdata_i
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        SPR_PRI   = 1'b0,
        HOST_TURN = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_starve_cnt;
    logic [CW-1:0]   w_starve_nxt;
    logic [CW-1:0]   w_starve_inc;
    logic            w_gnt_spr;
    logic            w_gnt_host;

    // Command stage
    logic            r_ram_en;
    logic            r_ram_we;
    logic [AWID-1:0] r_ram_addr;
    logic [DWID-1:0] r_ram_wdata;
    logic [BENW-1:0] r_ram_ben;

    // Tag pipeline: stage 1 travels with the command, stage 2 with the RAM data
    logic            r_tag1_rd;
    logic            r_tag1_host;
    logic            r_tag2_rd;
    logic            r_tag2_host;

    // Read return stage
    logic            r_spr_rvalid;
    logic            r_host_rvalid;
    logic [DWID-1:0] r_spr_rdata;
    logic [DWID-1:0] r_host_rdata;

    always_ff @(posedge clk_a_i or posedge rst_a_c) begin
        if (rst_a_c) begin
            r_state      <= SPR_PRI;
            r_starve_cnt <= '0;
        end else begin
            // NOTE: every sequential update uses <= so all flops sample pre-edge values.
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
        w_gnt_spr    = 1'b0;
        w_gnt_host   = 1'b0;
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        w_starve_inc = r_starve_cnt + 1'b1;

        case (r_state)
            SPR_PRI: begin
                if (spr_req_i) begin
                    w_gnt_spr = 1'b1;
                end else if (host_req_i) begin
                    w_gnt_host = 1'b1;
                end

                // Count only renderer wins that actually made a waiting host lose
                if (w_gnt_spr && host_req_i) begin
                    if (w_starve_inc == CW'(STARVE_MAX)) begin
                        w_state_nxt  = HOST_TURN;
                        w_starve_nxt = '0;
                    end else begin
                        w_starve_nxt = w_starve_inc;
                    end
                end else begin
                    w_starve_nxt = '0;
                end
            end

            HOST_TURN: begin
                if (host_req_i) begin
                    w_gnt_host = 1'b1;
                end else begin
                    w_gnt_spr = spr_req_i;
                end
                w_state_nxt  = SPR_PRI;
                w_starve_nxt = '0;
            end
        endcase
    end

    assign spr_ack_o  = w_gnt_spr;
    assign host_ack_o = w_gnt_host;

    // Address, data and enables hold through idle cycles; only en/we return to 0
    always_ff @(posedge clk_a_i or posedge rst_a_c) begin
        if (rst_a_c) begin
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_ben   <= '0;
        end else begin
            r_ram_en <= w_gnt_spr | w_gnt_host;
            r_ram_we <= w_gnt_host & host_we_i;
            if (w_gnt_host) begin
                r_ram_addr  <= host_addr_i;
                r_ram_wdata <= host_wdata_i;
                r_ram_ben   <= host_ben_i;
            end else if (w_gnt_spr) begin
                r_ram_addr <= spr_addr_i;
                r_ram_ben  <= '1;
            end
        end
    end

    always_ff @(posedge clk_a_i or posedge rst_a_c) begin
        if (rst_a_c) begin
            r_tag1_rd   <= 1'b0;
            r_tag1_host <= 1'b0;
            r_tag2_rd   <= 1'b0;
            r_tag2_host <= 1'b0;
        end else begin
            r_tag1_rd   <= w_gnt_spr | (w_gnt_host & ~host_we_i);
            r_tag1_host <= w_gnt_host;
            r_tag2_rd   <= r_tag1_rd;
            r_tag2_host <= r_tag1_host;
        end
    end

    always_ff @(posedge clk_a_i or posedge rst_a_c) begin
        if (rst_a_c) begin
            r_spr_rvalid  <= 1'b0;
            r_host_rvalid <= 1'b0;
            r_spr_rdata   <= '0;
            r_host_rdata  <= '0;
        end else begin
            r_spr_rvalid  <= r_tag2_rd & ~r_tag2_host;
            r_host_rvalid <= r_tag2_rd & r_tag2_host;
            if (r_tag2_rd && !r_tag2_host) begin
                r_spr_rdata <= ram_rdata_i;
            end
            if (r_tag2_rd && r_tag2_host) begin
                r_host_rdata <= ram_rdata_i;
            end
        end
    end

    assign ram_en_o      = r_ram_en;
    assign ram_we_o      = r_ram_we;
    assign ram_addr_o    = r_ram_addr;
    assign ram_wdata_o   = r_ram_wdata;
    assign ram_ben_o     = r_ram_ben;
    assign spr_rvalid_o  = r_spr_rvalid;
    assign spr_rdata_o   = r_spr_rdata;
    assign host_rvalid_o = r_host_rvalid;
    assign host_rdata_o  = r_host_rdata;

endmodule
